// File: rtl/glitch_pkg.sv
// Shared types for the glitch front end: edge-select encodings, trigger-qualifier
// FSM states and the default synchroniser depth.
package glitch_pkg;

  localparam int TQ_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_NONE = 2'b11
  } edge_sel_e;

  typedef enum logic [1:0] {
    TQ_IDLE    = 2'b00,
    TQ_ARMED   = 2'b01,
    TQ_HOLDOFF = 2'b10
  } tq_state_e;

  function automatic logic edge_qualifies(edge_sel_e sel, logic rise, logic fall);
    case (sel)
      EDGE_RISE: return rise;
      EDGE_FALL: return fall;
      EDGE_BOTH: return rise | fall;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/trig_filter.sv
// Synchroniser plus optional deglitch filter for the raw target trigger.
// Filter built only when TRIG_DEGLITCH_FILTER_EN is defined; otherwise filtered = synced delayed one cycle.
module trig_filter
  import glitch_pkg::*;
#(
  parameter int SYNC_STAGES = TQ_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig_raw_i,
  input  logic [7:0] filter_len_i,
  output logic       filtered
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], trig_raw_i};
  end

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef TRIG_DEGLITCH_FILTER_EN
  logic [7:0] run_cnt;

  // run_cnt holds prior disagreeing edges; adopting on the (filter_len+1)-th keeps len=0 transparent.
  always_ff @(posedge clk) begin
    if (rst) begin
      filtered <= 1'b0;
      run_cnt  <= '0;
    end else if (synced == filtered) begin
      run_cnt <= '0;
    end else if (run_cnt >= filter_len_i) begin
      filtered <= synced;
      run_cnt  <= '0;
    end else begin
      run_cnt <= run_cnt + 8'd1;
    end
  end
`else
  logic unused_filter_len;
  assign unused_filter_len = ^filter_len_i;

  always_ff @(posedge clk) begin
    if (rst) filtered <= 1'b0;
    else     filtered <= synced;
  end
`endif

endmodule

// File: rtl/trigger_qualifier.sv
// Qualifies the conditioned target trigger: edge select, Nth-edge count after arm, one-cycle pulse, hold-off.
// Deglitch filter in trig_filter is enabled by defining TRIG_DEGLITCH_FILTER_EN.
module trigger_qualifier
  import glitch_pkg::*;
#(
  parameter int SYNC_STAGES = TQ_SYNC_STAGES,
  parameter int HOLDOFF_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trig_raw_i,
  input  logic [1:0]           edge_sel_i,
  input  logic [7:0]           filter_len_i,
  input  logic [7:0]           edge_count_i,
  input  logic [HOLDOFF_W-1:0] holdoff_i,
  input  logic                 arm_i,
  output logic                 trigger_o,
  output logic                 busy_o,
  output logic [7:0]           edge_cnt_o
);

  localparam logic [HOLDOFF_W-1:0] HOLD_ONE = HOLDOFF_W'(1);

  logic                 filtered;
  logic                 prev;
  logic                 qualify;
  logic [7:0]           next_cnt;
  tq_state_e            state;
  edge_sel_e            sel_q;
  logic [7:0]           count_q;
  logic [HOLDOFF_W-1:0] holdoff_q;
  logic [HOLDOFF_W-1:0] hold_cnt;

  trig_filter #(.SYNC_STAGES(SYNC_STAGES)) u_filter (
    .clk          (clk),
    .rst          (rst),
    .trig_raw_i   (trig_raw_i),
    .filter_len_i (filter_len_i),
    .filtered     (filtered)
  );

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= filtered;
  end

  assign qualify  = edge_qualifies(sel_q, filtered & ~prev, ~filtered & prev);
  assign next_cnt = edge_cnt_o + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= TQ_IDLE;
      trigger_o  <= 1'b0;
      busy_o     <= 1'b0;
      edge_cnt_o <= '0;
      sel_q      <= EDGE_RISE;
      count_q    <= '0;
      holdoff_q  <= '0;
      hold_cnt   <= '0;
    end else begin
      trigger_o <= 1'b0;
      // An arm outside HOLDOFF always wins, including over an edge in the same cycle.
      if (arm_i && state != TQ_HOLDOFF) begin
        state      <= TQ_ARMED;
        busy_o     <= 1'b1;
        edge_cnt_o <= '0;
        sel_q      <= edge_sel_e'(edge_sel_i);
        count_q    <= (edge_count_i == 8'd0) ? 8'd1 : edge_count_i;
        holdoff_q  <= holdoff_i;
      end else begin
        case (state)
          TQ_ARMED: begin
            if (qualify) begin
              edge_cnt_o <= next_cnt;
              if (next_cnt == count_q) begin
                trigger_o <= 1'b1;
                hold_cnt  <= (holdoff_q == '0) ? '0 : holdoff_q - HOLD_ONE;
                state     <= TQ_HOLDOFF;
              end
            end
          end
          TQ_HOLDOFF: begin
            if (hold_cnt == '0) begin
              state  <= TQ_IDLE;
              busy_o <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt - HOLD_ONE;
            end
          end
          TQ_IDLE: ;
          default: begin
            state  <= TQ_IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
